// File: rtl/program_loader_pkg.sv
// -----------------------------------------------------------------------------
// program_loader_pkg
// Shared definitions for the boot-time program loader:
//   - INSTR_START_PC / DATA_START_PC : bounds of the DRAM instruction region
//   - loader_state_e                 : loader FSM state encoding
//   - word_addr()                    : byte address of an instruction word
// No ports (package).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package program_loader_pkg;

  // First instruction byte address and last instruction-region byte address.
  localparam int unsigned INSTR_START_PC = 32'd0;
  localparam int unsigned DATA_START_PC  = 32'd127;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ASSEMBLE = 3'd1,
    WRITE    = 3'd2,
    DONE     = 3'd3,
    ERROR    = 3'd4
  } loader_state_e;

  // Byte address of word number idx, counted from base (words are 4 bytes).
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    word_addr = base + {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// program_loader_byte_packer
// Packs bytes into a little-endian 32-bit word (first byte -> bits 7:0).
// Ports:
//   i_clock, i_reset  : clock, synchronous active-high reset
//   i_clear           : synchronous clear of byte count and partial word
//   i_accept          : i_byte is consumed this cycle
//   i_byte            : incoming byte
//   o_word            : partial word with i_byte merged into the current lane;
//                       this is the complete word when o_word_full is high
//   o_word_full       : the byte accepted this cycle completes the word
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module program_loader_byte_packer
  import program_loader_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  logic [1:0]  r_byte_cnt;
  logic [31:0] r_shift;
  logic [31:0] w_merged;

  // Merge the incoming byte into the lane selected by the byte counter.
  always_comb begin
    w_merged = r_shift;
    case (r_byte_cnt)
      2'd0:    w_merged[7:0]   = i_byte;
      2'd1:    w_merged[15:8]  = i_byte;
      2'd2:    w_merged[23:16] = i_byte;
      2'd3:    w_merged[31:24] = i_byte;
      default: w_merged        = r_shift;
    endcase
  end

  // The full word is exposed in the same cycle as its last byte so the
  // loader can register it straight into its write-data output.
  assign o_word      = w_merged;
  assign o_word_full = i_accept && (r_byte_cnt == 2'd3);

  // Byte counter and lane register; a completed word restarts from zero.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_byte_cnt <= 2'd0;
      r_shift    <= 32'd0;
    end else if (o_word_full) begin
      r_byte_cnt <= 2'd0;
      r_shift    <= 32'd0;
    end else if (i_accept) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
      r_shift    <= w_merged;
    end else begin
      r_byte_cnt <= r_byte_cnt;
      r_shift    <= r_shift;
    end
  end

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Boot-time loader: receives a program as a byte stream, packs it into
// little-endian words, writes them to the DRAM instruction region and then
// releases the core from reset.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   load_start_ip/len_ip    : start pulse and word count (sampled in IDLE)
//   byte_valid_ip/data_ip   : byte stream in; byte_ready_op back-pressure
//   mem_wr_en/addr/data_op  : DRAM write request, held until mem_gnt_ip
//   mem_en_op               : DRAM enable
//   core_reset_op           : core reset, low once the load has completed
//   done_op / error_op      : load finished / illegal length requested
// All outputs are registers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned START_ADDR = INSTR_START_PC,
  parameter int unsigned MAX_WORDS  = (DATA_START_PC + 1) / 4,
  parameter int unsigned LEN_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_start_ip,
  input  logic [LEN_W-1:0] load_len_ip,
  input  logic             byte_valid_ip,
  input  logic [7:0]       byte_data_ip,
  output logic             byte_ready_op,
  output logic             mem_wr_en_op,
  output logic [31:0]      mem_wr_addr_op,
  output logic [31:0]      mem_wr_data_op,
  input  logic             mem_gnt_ip,
  output logic             mem_en_op,
  output logic             core_reset_op,
  output logic             done_op,
  output logic             error_op
);

  localparam int unsigned CNT_W        = $clog2(MAX_WORDS) + 1;
  localparam logic [31:0] START_ADDR_W = 32'(START_ADDR);
  localparam logic [31:0] MAX_WORDS_W  = 32'(MAX_WORDS);

  loader_state_e     r_state;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [CNT_W-1:0]  r_last_idx;
  logic              r_byte_ready;
  logic              r_wr_en;
  logic [31:0]       r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_mem_en;
  logic              r_core_reset;
  logic              r_done;
  logic              r_error;

  logic              w_len_ok;
  logic              w_accept;
  logic              w_clear;
  logic [31:0]       w_word;
  logic              w_word_full;

  // Legal length is 1..MAX_WORDS, compared unsigned in 32 bits.
  assign w_len_ok = (load_len_ip != {LEN_W{1'b0}}) &&
                    (32'(load_len_ip) <= MAX_WORDS_W);

  // byte_ready is only ever high in ASSEMBLE, so this also gates by state.
  assign w_accept = byte_valid_ip & r_byte_ready;
  assign w_clear  = (r_state == IDLE);

  program_loader_byte_packer u_packer (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_clear     (w_clear),
    .i_accept    (w_accept),
    .i_byte      (byte_data_ip),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_word_cnt   <= {CNT_W{1'b0}};
      r_last_idx   <= {CNT_W{1'b0}};
      r_byte_ready <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 32'd0;
      r_wr_data    <= 32'd0;
      r_mem_en     <= 1'b0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_start_ip) begin
            if (w_len_ok) begin
              // Stored as len-1 so the last-word test is a plain equality.
              r_last_idx   <= CNT_W'(load_len_ip - {{(LEN_W-1){1'b0}}, 1'b1});
              r_word_cnt   <= {CNT_W{1'b0}};
              r_byte_ready <= 1'b1;
              r_state      <= ASSEMBLE;
            end else begin
              r_error      <= 1'b1;
              r_state      <= ERROR;
            end
          end else begin
            r_state <= IDLE;
          end
        end

        ASSEMBLE: begin
          if (w_word_full) begin
            r_byte_ready <= 1'b0;
            r_wr_en      <= 1'b1;
            r_wr_addr    <= word_addr(START_ADDR_W, 32'(r_word_cnt));
            r_wr_data    <= w_word;
            r_mem_en     <= 1'b1;
            r_state      <= WRITE;
          end else begin
            r_state <= ASSEMBLE;
          end
        end

        WRITE: begin
          if (mem_gnt_ip) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= 32'd0;
            r_wr_data <= 32'd0;
            if (r_word_cnt == r_last_idx) begin
              r_mem_en     <= 1'b1;
              r_core_reset <= 1'b0;
              r_done       <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_word_cnt   <= r_word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
              r_mem_en     <= 1'b0;
              r_byte_ready <= 1'b1;
              r_state      <= ASSEMBLE;
            end
          end else begin
            r_state <= WRITE;
          end
        end

        DONE: begin
          r_state <= DONE;
        end

        ERROR: begin
          r_state <= ERROR;
        end

        default: begin
          // Unreachable encoding: fall back to the reset state, core held.
          r_state      <= IDLE;
          r_byte_ready <= 1'b0;
          r_wr_en      <= 1'b0;
          r_wr_addr    <= 32'd0;
          r_wr_data    <= 32'd0;
          r_mem_en     <= 1'b0;
          r_core_reset <= 1'b1;
          r_done       <= 1'b0;
          r_error      <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready_op  = r_byte_ready;
  assign mem_wr_en_op   = r_wr_en;
  assign mem_wr_addr_op = r_wr_addr;
  assign mem_wr_data_op = r_wr_data;
  assign mem_en_op      = r_mem_en;
  assign core_reset_op  = r_core_reset;
  assign done_op        = r_done;
  assign error_op       = r_error;

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps

module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_start_ip = 1'b0;
  logic [7:0]  load_len_ip = 8'd0;
  logic        byte_valid_ip = 1'b0;
  logic [7:0]  byte_data_ip = 8'd0;
  logic        byte_ready_op;
  logic        mem_wr_en_op;
  logic [31:0] mem_wr_addr_op;
  logic [31:0] mem_wr_data_op;
  logic        mem_gnt_ip = 1'b0;
  logic        mem_en_op;
  logic        core_reset_op;
  logic        done_op;
  logic        error_op;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  program_loader dut (
    .clock          (clock),
    .reset          (reset),
    .load_start_ip  (load_start_ip),
    .load_len_ip    (load_len_ip),
    .byte_valid_ip  (byte_valid_ip),
    .byte_data_ip   (byte_data_ip),
    .byte_ready_op  (byte_ready_op),
    .mem_wr_en_op   (mem_wr_en_op),
    .mem_wr_addr_op (mem_wr_addr_op),
    .mem_wr_data_op (mem_wr_data_op),
    .mem_gnt_ip     (mem_gnt_ip),
    .mem_en_op      (mem_en_op),
    .core_reset_op  (core_reset_op),
    .done_op        (done_op),
    .error_op       (error_op)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load_start_ip = 1'b0;
    byte_valid_ip = 1'b0;
    mem_gnt_ip = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start(input logic [7:0] len);
    load_start_ip = 1'b1;
    load_len_ip = len;
    tick();
    load_start_ip = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    byte_valid_ip = 1'b1;
    byte_data_ip = b;
    while (byte_ready_op !== 1'b1 && waited < 20) begin
      tick();
      waited = waited + 1;
    end
    check1("byte_ready_wait", byte_ready_op, 1'b1);
    tick();
    byte_valid_ip = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_ready"},  byte_ready_op, 1'b0);
    check1({tag, "_wr_en"},  mem_wr_en_op,  1'b0);
    check ({tag, "_addr"},   mem_wr_addr_op, 32'h0);
    check ({tag, "_data"},   mem_wr_data_op, 32'h0);
    check1({tag, "_mem_en"}, mem_en_op,     1'b0);
    check1({tag, "_core_rst"}, core_reset_op, 1'b1);
    check1({tag, "_done"},   done_op,       1'b0);
    check1({tag, "_error"},  error_op,      1'b0);
  endtask

  initial begin
    logic [31:0] words [3];
    logic [31:0] w;
    logic [7:0]  ib;
    logic [7:0]  vbytes [4];
    words[0] = 32'h11223344;
    words[1] = 32'hAABBCCDD;
    words[2] = 32'hDEADBEEF;
    vbytes[0] = 8'h01; vbytes[1] = 8'h02; vbytes[2] = 8'h03; vbytes[3] = 8'h04;

    // ---- 1: reset state, single word with grant tied high ----
    do_reset();
    check_reset_outputs("rst");
    mem_gnt_ip = 1'b1;
    start(8'd1);
    check1("t1_ready_first", byte_ready_op, 1'b1);
    check1("t1_no_wr_yet", mem_wr_en_op, 1'b0);
    send_word(32'h00000013);
    check1("t1_wr_en", mem_wr_en_op, 1'b1);
    check ("t1_addr", mem_wr_addr_op, 32'h0);
    check ("t1_data", mem_wr_data_op, 32'h00000013);
    check1("t1_mem_en_w", mem_en_op, 1'b1);
    check1("t1_core_rst_w", core_reset_op, 1'b1);
    check1("t1_ready_w", byte_ready_op, 1'b0);
    tick();
    check1("t1_done", done_op, 1'b1);
    check1("t1_core_rst", core_reset_op, 1'b0);
    check1("t1_mem_en", mem_en_op, 1'b1);
    check1("t1_wr_off", mem_wr_en_op, 1'b0);
    check ("t1_data_off", mem_wr_data_op, 32'h0);

    // ---- 2: three words, grant delayed 4 cycles each ----
    do_reset();
    start(8'd3);
    for (int k = 0; k < 3; k++) begin
      send_word(words[k]);
      check1("t2_wr_en", mem_wr_en_op, 1'b1);
      check ("t2_addr", mem_wr_addr_op, 32'(4 * k));
      check ("t2_data", mem_wr_data_op, words[k]);
      for (int c = 0; c < 4; c++) begin
        tick();
        check1("t2_wait_wr_en", mem_wr_en_op, 1'b1);
        check ("t2_wait_addr", mem_wr_addr_op, 32'(4 * k));
        check ("t2_wait_data", mem_wr_data_op, words[k]);
        check1("t2_wait_ready", byte_ready_op, 1'b0);
      end
      mem_gnt_ip = 1'b1;
      tick();
      mem_gnt_ip = 1'b0;
      check1("t2_wr_dropped", mem_wr_en_op, 1'b0);
    end
    check1("t2_done", done_op, 1'b1);
    check1("t2_core_rst", core_reset_op, 1'b0);

    // ---- 3: byte_valid toggling, lane order ----
    do_reset();
    start(8'd1);
    for (int i = 0; i < 4; i++) begin
      byte_valid_ip = 1'b1;
      byte_data_ip = vbytes[i];
      tick();
      byte_valid_ip = 1'b0;
      byte_data_ip = 8'hEE;
      if (i < 3) begin
        tick();
        check1("t3_stall_no_wr", mem_wr_en_op, 1'b0);
      end
    end
    check1("t3_wr_en", mem_wr_en_op, 1'b1);
    check ("t3_data", mem_wr_data_op, 32'h04030201);
    mem_gnt_ip = 1'b1;
    tick();
    mem_gnt_ip = 1'b0;
    check1("t3_done", done_op, 1'b1);

    // ---- 4: illegal lengths 0 and 33 ----
    do_reset();
    start(8'd0);
    check1("t4a_error", error_op, 1'b1);
    check1("t4a_core_rst", core_reset_op, 1'b1);
    check1("t4a_mem_en", mem_en_op, 1'b0);
    start(8'd1);
    byte_valid_ip = 1'b1;
    byte_data_ip = 8'h55;
    for (int c = 0; c < 6; c++) begin
      tick();
      check1("t4a_no_wr", mem_wr_en_op, 1'b0);
      check1("t4a_no_ready", byte_ready_op, 1'b0);
    end
    check1("t4a_error_sticky", error_op, 1'b1);
    byte_valid_ip = 1'b0;
    do_reset();
    check1("t4_error_cleared", error_op, 1'b0);
    start(8'd33);
    check1("t4b_error", error_op, 1'b1);
    check1("t4b_core_rst", core_reset_op, 1'b1);
    check1("t4b_no_ready", byte_ready_op, 1'b0);
    tick();
    check1("t4b_no_wr", mem_wr_en_op, 1'b0);

    // ---- 5: full capacity, 32 words ----
    do_reset();
    mem_gnt_ip = 1'b1;
    start(8'd32);
    for (int i = 0; i < 32; i++) begin
      ib = 8'(i);
      w = {ib, 8'hA5, ~ib, 8'h5A};
      send_word(w);
      check ("t5_addr", mem_wr_addr_op, 32'(4 * i));
      check ("t5_data", mem_wr_data_op, w);
      tick();
    end
    check1("t5_done", done_op, 1'b1);
    check1("t5_core_rst", core_reset_op, 1'b0);
    load_start_ip = 1'b1;
    load_len_ip = 8'd1;
    byte_valid_ip = 1'b1;
    byte_data_ip = 8'h99;
    for (int c = 0; c < 6; c++) begin
      tick();
      load_start_ip = 1'b0;
      check1("t5_done_no_wr", mem_wr_en_op, 1'b0);
      check1("t5_done_no_ready", byte_ready_op, 1'b0);
      check1("t5_done_sticky", done_op, 1'b1);
    end
    byte_valid_ip = 1'b0;
    mem_gnt_ip = 1'b0;

    // ---- 6: reset mid-word discards partial bytes ----
    do_reset();
    mem_gnt_ip = 1'b1;
    start(8'd2);
    send_word(32'h13121110);
    check ("t6_w0_data", mem_wr_data_op, 32'h13121110);
    tick();
    send_byte(8'h21);
    send_byte(8'h22);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("t6_rst");
    start(8'd1);
    send_word(32'h34333231);
    check1("t6_wr_en", mem_wr_en_op, 1'b1);
    check ("t6_addr", mem_wr_addr_op, 32'h0);
    check ("t6_data", mem_wr_data_op, 32'h34333231);
    tick();
    check1("t6_done", done_op, 1'b1);
    mem_gnt_ip = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
